// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED output PIO: register address map.
package led_pio_pkg;

   localparam int ADDR_W = 2;

   typedef logic [ADDR_W-1:0] addr_t;

   // Write-side register map
   localparam addr_t ADDR_DATA     = 2'd0;
   localparam addr_t ADDR_BLINK    = 2'd1;
   localparam addr_t ADDR_OUTSET   = 2'd2;
   localparam addr_t ADDR_OUTCLEAR = 2'd3;

   // Read-side aliases for the same two upper addresses
   localparam addr_t ADDR_PIN      = 2'd2;
   localparam addr_t ADDR_PHASE    = 2'd3;

endpackage : led_pio_pkg

// File: rtl/led_pio_out_blink_prescaler.sv
// Free-running blink prescaler: divides clk into a square-wave phase with a
// half-period of BLINK_DIV cycles. A restart forces a fresh "on" half-period.
module blink_prescaler #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic phase
);

   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             phase_q, phase_d;

   // Next-state: restart wins over the wrap so the first "on" interval is a full half-period
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      count_d = count_q + CNT_ONE;
      phase_d = phase_q;
      if (restart) begin
         count_d = '0;
         phase_d = 1'b1;
      end else if (count_q == CNT_MAX) begin
         count_d = '0;
         phase_d = ~phase_q;
      end
   end

   // Counter and phase flops
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) begin
         count_q <= '0;
         phase_q <= 1'b0;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule : blink_prescaler

// File: rtl/led_pio_out.sv
// Avalon-MM output PIO for the LED bank: DATA register with atomic set/clear,
// per-bit blink mask gated by the prescaled phase, registered pin drive and
// registered read data (latency 1).
module led_pio_out
   import led_pio_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter int               BLINK_DIV   = 25000000,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [WIDTH-1:0] writedata,
   input  logic             read,
   output logic [WIDTH-1:0] readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q,  data_d;
   logic [WIDTH-1:0] blink_q, blink_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             phase;
   logic             blink_restart;

   // A BLINK write restarts the prescaler into a fresh "on" half-period
   assign blink_restart = write && (address == ADDR_BLINK);

   blink_prescaler #(
      .BLINK_DIV (BLINK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (blink_restart),
      .phase   (phase)
   );

   // Register-file write decode, including atomic set/clear of DATA
   always_comb begin
      data_d  = data_q;
      blink_d = blink_q;
      if (write) begin
         case (address)
            ADDR_DATA:     data_d  = writedata;
            ADDR_BLINK:    blink_d = writedata;
            ADDR_OUTSET:   data_d  = data_q | writedata;
            ADDR_OUTCLEAR: data_d  = data_q & ~writedata;
            default:       ;
         endcase
      end
   end

   // Pin function: blinking bits are forced low while phase is 0
   always_comb begin
      out_d = data_q & ~(blink_q & {WIDTH{~phase}});
   end

   // Read mux samples pre-write state, so a same-cycle write is not visible yet
   always_comb begin
      rdata_d = '0;
      if (read) begin
         case (address)
            ADDR_DATA:  rdata_d = data_q;
            ADDR_BLINK: rdata_d = blink_q;
            ADDR_PIN:   rdata_d = out_q;
            ADDR_PHASE: rdata_d = WIDTH'(phase);
            default:    rdata_d = '0;
         endcase
      end
   end

   // Register file, output flop and read-data flop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= RESET_VALUE;
         blink_q <= '0;
         out_q   <= RESET_VALUE;
         rdata_q <= '0;
      end else begin
         data_q  <= data_d;
         blink_q <= blink_d;
         out_q   <= out_d;
         rdata_q <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign out_port = out_q;

endmodule : led_pio_out
